// File: rtl/seg_display.sv
// seg_display -- 8-digit multiplexed 7-segment driver with bus-mapped DATA/CTRL registers.
// Rev 1.0
`default_nettype none

module seg_display #(
  parameter int unsigned CLKRATE = 25000000,
  parameter int unsigned SCANHZ  = 1000,
  parameter int unsigned ADDR    = 411704
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] busaddr,
  input  logic        buswe,
  input  logic [31:0] buswdata,
  output logic [31:0] busrdata,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned SCANMAX   = CLKRATE / SCANHZ;
  localparam int          CW        = (SCANMAX > 1) ? $clog2(SCANMAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCANMAX - 1);
  localparam logic [31:0] DATA_ADDR = ADDR;
  localparam logic [31:0] CTRL_ADDR = ADDR + 32'd4;

  typedef enum logic [0:0] {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   data_q, data_d;
  logic [15:0]   ctrl_q, ctrl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic [3:0]    nibble;
  logic [7:0]    dp_mask;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Read mux sees register contents before any same-cycle write lands.
  always_comb begin
    busrdata = 32'h0;
    if (busaddr == DATA_ADDR) begin
      busrdata = data_q;
    end else if (busaddr == CTRL_ADDR) begin
      busrdata = {16'h0, ctrl_q};
    end
  end

  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (buswe && (busaddr == DATA_ADDR)) begin
      data_d = buswdata;
    end
    if (buswe && (busaddr == CTRL_ADDR)) begin
      ctrl_d = buswdata[15:0];
    end

    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;

    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      SHOW: begin
        if (tick) begin
          state_d = BLANK;
          idx_d   = idx_q + 3'd1;
        end
      end
      default: state_d = SHOW;
    endcase

    // Outputs follow the current registers, so they trail any register update by one edge.
    nibble  = 4'(data_q >> {idx_q, 2'b00});
    dp_mask = ctrl_q[15:8];
    an_d    = 8'hFF;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    if (state_q == SHOW) begin
      an_d[idx_q] = ~ctrl_q[idx_q];
      seg_d       = hex7(nibble);
      dp_d        = ~dp_mask[idx_q];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= SHOW;
      data_q  <= 32'h0;
      ctrl_q  <= 16'h00FF;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

`default_nettype wire
